approx_multiplier_pipe: RTL and testbench

Parametrised, pipelined unsigned WIDTH×WIDTH multiplier whose partial-product tree is reduced by cascaded 4:2 compressor levels. The low APPROX_COLS columns use approximate compressors when the per-operation `mode` bit is set; otherwise every column is exact. It is the datapath successor to the single combinational compressor cell. It sits behind a valid/ready stream and carries the mode bit with its data.

---
 rtl/approx_mult_pkg.sv | 49 ++++
 rtl/compressor42_cell.sv | 34 +++
 rtl/approx_multiplier_pipe.sv | 126 ++++++++++++
 tb/tb_approx_multiplier_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared constants and elaboration helpers for the approximate 4:2-compressor multiplier.
// The helpers size the reduction tree: row counts per level, level count and flat row offsets.
package approx_mult_pkg;

    localparam int   WIDTH_DEFAULT = 8;
    localparam int   PW            = 2 * WIDTH_DEFAULT;
    localparam logic MODE_EXACT    = 1'b0;
    localparam logic MODE_APPROX   = 1'b1;

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

    // Each group of four rows collapses to a sum row and a carry row.
    function automatic int next_rows(input int rows);
        return 2 * ((rows + 3) / 4);
    endfunction

    function automatic int num_levels(input int width);
        int rows;
        int lv;
        rows = width;
        lv   = 0;
        while (rows > 2) begin
            rows = next_rows(rows);
            lv++;
        end
        return lv;
    endfunction

    function automatic int rows_at_level(input int width, input int level);
        int rows;
        rows = width;
        for (int i = 0; i < level; i++) begin
            rows = next_rows(rows);
        end
        return rows;
    endfunction

    function automatic int row_base(input int width, input int level);
        int base;
        base = 0;
        for (int i = 0; i < level; i++) begin
            base += rows_at_level(width, i);
        end
        return base;
    endfunction

endpackage

// File: rtl/compressor42_cell.sv
// One column slice of a 4:2 compressor: two chained full adders when exact,
// or the carry-free approximate cell when approx_en is set.
module compressor42_cell (
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic x4,
    input  logic cin,
    input  logic approx_en,
    output logic sum,
    output logic carry,
    output logic cout
);

    logic s1;
    logic c1;
    logic x34;

    always_comb begin
        s1  = x1 ^ x2 ^ x3;
        c1  = (x1 & x2) | (x1 & x3) | (x2 & x3);
        x34 = x3 ^ x4;
        if (approx_en) begin
            sum   = (x34 & x1 & x2) | (~x34 & (x1 | x2));
            carry = x3 | x4;
            cout  = 1'b0;
        end else begin
            sum   = s1 ^ x4 ^ cin;
            carry = (s1 & x4) | (s1 & cin) | (x4 & cin);
            cout  = c1;
        end
    end

endmodule

// File: rtl/approx_multiplier_pipe.sv
// Three-stage unsigned multiplier: operand register, 4:2 compressor tree, final add.
// The low APPROX_COLS columns switch to approximate cells per beat via the mode bit.
module approx_multiplier_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 out_mode
);

    localparam int PROD_W = prod_width(WIDTH);
    localparam int LEVELS = num_levels(WIDTH);
    localparam int NROWS  = row_base(WIDTH, LEVELS) + 2;

    logic                stall;
    logic                adv;
    logic                vld_p1;
    logic                vld_p2;
    logic [WIDTH-1:0]    a_p1;
    logic [WIDTH-1:0]    b_p1;
    logic                mode_p1;
    logic                mode_p2;
    logic                approx_sel;
    logic [PROD_W-1:0]   sum_row_p2;
    logic [PROD_W-1:0]   carry_row_p2;
    logic [PROD_W-1:0]   tree [NROWS];

    // The whole pipe freezes on output backpressure; bubbles are kept.
    assign stall      = out_valid & ~out_ready;
    assign adv        = ~stall;
    assign in_ready   = adv;
    assign approx_sel = (mode_p1 == MODE_APPROX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            product   <= '0;
            out_mode  <= 1'b0;
        end else if (adv) begin
            vld_p1    <= in_valid;
            vld_p2    <= vld_p1;
            out_valid <= vld_p2;
            product   <= sum_row_p2 + carry_row_p2;
            out_mode  <= mode_p2;
        end
    end

    // ---- stage 1 -> 2 boundary: operands in, reduced row pair out ----
    always_ff @(posedge clk) begin
        if (adv) begin
            a_p1         <= a;
            b_p1         <= b;
            mode_p1      <= mode;
            sum_row_p2   <= tree[NROWS-2];
            carry_row_p2 <= tree[NROWS-1];
            mode_p2      <= mode_p1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        assign tree[i] = {{WIDTH{1'b0}}, a_p1 & {WIDTH{b_p1[i]}}} << i;
    end

    // Level l reads rows at tree[IN_BASE +: NIN] and writes S/C pairs at OUT_BASE.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int IN_BASE  = row_base(WIDTH, l);
        localparam int NIN      = rows_at_level(WIDTH, l);
        localparam int OUT_BASE = row_base(WIDTH, l + 1);
        localparam int NGRP     = (NIN + 3) / 4;

        for (genvar k = 0; k < NGRP; k++) begin : g_grp
            logic [PROD_W-1:0] x [4];
            logic [PROD_W-1:0] sum_v;
            logic [PROD_W-1:0] carry_v;
            logic [PROD_W-1:0] cout_v;
            logic [PROD_W-1:0] cin_v;
            logic              unused_msbs;

            for (genvar m = 0; m < 4; m++) begin : g_in
                if (4 * k + m < NIN) begin : g_row
                    assign x[m] = tree[IN_BASE + 4*k + m];
                end else begin : g_zero
                    assign x[m] = '0;
                end
            end

            assign cin_v = {cout_v[PROD_W-2:0], 1'b0};

            for (genvar j = 0; j < PROD_W; j++) begin : g_col
                localparam bit APPROX_COL = (j < APPROX_COLS);

                compressor42_cell u_cell (
                    .x1        (x[0][j]),
                    .x2        (x[1][j]),
                    .x3        (x[2][j]),
                    .x4        (x[3][j]),
                    .cin       (cin_v[j]),
                    .approx_en (approx_sel & APPROX_COL),
                    .sum       (sum_v[j]),
                    .carry     (carry_v[j]),
                    .cout      (cout_v[j])
                );
            end

            // Carries out of the top column fall off the truncated product.
            assign unused_msbs = cout_v[PROD_W-1] ^ carry_v[PROD_W-1];

            assign tree[OUT_BASE + 2*k]     = sum_v;
            assign tree[OUT_BASE + 2*k + 1] = {carry_v[PROD_W-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_approx_multiplier_pipe.sv
// Scoreboard bench: drivers queue expected results on accept, monitors pop on output handshakes.
module tb_approx_multiplier_pipe;

    typedef struct packed {
        logic        chk;
        logic        m;
        logic [15:0] p;
    } exp8_t;

    typedef struct packed {
        logic        m;
        logic [31:0] p;
    } exp16_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] product;
    logic        out_mode;

    logic        in_ready0;
    logic        out_valid0;
    logic [15:0] product0;
    logic        out_mode0;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        mode16 = 1'b0;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [31:0] product16;
    logic        out_mode16;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          lat_arm_cnt = 0;
    int          lat_done_cnt = 0;
    logic        arm_lat = 1'b0;
    logic        bp_en = 1'b0;
    logic        hold_en = 1'b0;
    logic [3:0]  bp_pat = 4'b1001;
    int          bp_idx = 0;

    exp8_t       q8[$];
    exp8_t       q0[$];
    exp16_t      q16[$];

    approx_multiplier_pipe #(.WIDTH(8), .APPROX_COLS(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .out_mode(out_mode)
    );

    approx_multiplier_pipe #(.WIDTH(8), .APPROX_COLS(0)) dut_exact (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid0), .out_ready(out_ready),
        .product(product0), .out_mode(out_mode0)
    );

    approx_multiplier_pipe #(.WIDTH(16), .APPROX_COLS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .mode(mode16), .out_valid(out_valid16), .out_ready(out_ready16),
        .product(product16), .out_mode(out_mode16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Primary DUT monitor
    logic        prev_stall = 1'b0;
    logic [15:0] held_p = '0;
    logic        held_m = 1'b0;
    exp8_t       e8;
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            check("in_ready_vs_stall", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
            if (out_valid && prev_stall) begin
                check("hold_product", {48'd0, product}, {48'd0, held_p});
                check("hold_out_mode", {63'd0, out_mode}, {63'd0, held_m});
            end
            if (out_valid && lat_arm_cnt != lat_done_cnt) begin
                check("latency", 64'(cyc - acc_cyc), 64'd3);
                lat_done_cnt = lat_arm_cnt;
            end
            if (out_valid && out_ready) begin
                if (q8.size() == 0) begin
                    check("unexpected_beat", {63'd0, out_valid}, 64'd0);
                end else begin
                    e8 = q8.pop_front();
                    if (e8.chk) check("product", {48'd0, product}, {48'd0, e8.p});
                    check("out_mode", {63'd0, out_mode}, {63'd0, e8.m});
                end
            end
            prev_stall = out_valid && !out_ready;
            held_p     = product;
            held_m     = out_mode;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // APPROX_COLS=0 DUT monitor: always exact
    exp8_t e0;
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            check("exact_in_ready", {63'd0, in_ready0}, {63'd0, !(out_valid0 && !out_ready)});
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) begin
                    check("exact_unexpected_beat", {63'd0, out_valid0}, 64'd0);
                end else begin
                    e0 = q0.pop_front();
                    check("exact_product", {48'd0, product0}, {48'd0, e0.p});
                    check("exact_out_mode", {63'd0, out_mode0}, {63'd0, e0.m});
                end
            end
        end
    end

    // WIDTH=16 DUT monitor
    exp16_t e16;
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid16) begin
            if (q16.size() == 0) begin
                check("w16_unexpected_beat", {63'd0, out_valid16}, 64'd0);
            end else begin
                e16 = q16.pop_front();
                check("w16_product", {32'd0, product16}, {32'd0, e16.p});
                check("w16_out_mode", {63'd0, out_mode16}, {63'd0, e16.m});
            end
        end
    end

    task automatic set_ready();
        if (hold_en) begin
            out_ready = 1'b0;
        end else if (bp_en) begin
            out_ready = bp_pat[bp_idx % 4];
            bp_idx++;
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic mv,
                         input logic chk, input logic [15:0] ev);
        int guard;
        guard = 0;
        a = av; b = bv; mode = mv; in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            set_ready();
            #1;
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", {63'd0, in_ready}, 64'd1);
        end else begin
            q8.push_back('{chk, mv, ev});
            q0.push_back('{1'b1, mv, 16'(av) * 16'(bv)});
            if (arm_lat) begin
                acc_cyc = cyc;
                lat_arm_cnt++;
            end
        end
        @(negedge clk);
        set_ready();
        in_valid = 1'b0;
    endtask

    task automatic drain8();
        int guard;
        guard = 0;
        while ((q8.size() != 0 || q0.size() != 0) && guard < 300) begin
            @(negedge clk);
            set_ready();
            guard++;
        end
        check("drain_outstanding", 64'(q8.size() + q0.size()), 64'd0);
        q8.delete();
        q0.delete();
        repeat (2) begin
            @(negedge clk);
            set_ready();
        end
    endtask

    task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic mv,
                          input logic [31:0] ev);
        int guard;
        guard = 0;
        a16 = av; b16 = bv; mode16 = mv; in_valid16 = 1'b1;
        #1;
        while (!in_ready16 && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready16) check("w16_accept_timeout", {63'd0, in_ready16}, 64'd1);
        else q16.push_back('{mv, ev});
        @(negedge clk);
        in_valid16 = 1'b0;
    endtask

    task automatic drain16();
        int guard;
        guard = 0;
        while (q16.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("w16_drain_outstanding", 64'(q16.size()), 64'd0);
        q16.delete();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] wa;
        logic [15:0] wb;

        repeat (3) @(negedge clk);
        #2;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_product", {48'd0, product}, 64'd0);
        check("rst_out_mode", {63'd0, out_mode}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_w16_product", {32'd0, product16}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_ready();

        // Approximate directed beats, hand-reduced through the tree
        arm_lat = 1'b1;
        send8(8'd1, 8'd1, 1'b1, 1'b1, 16'd1);
        arm_lat = 1'b0;
        send8(8'd3,   8'd3,   1'b1, 1'b1, 16'd7);
        send8(8'd1,   8'd12,  1'b1, 1'b1, 16'd24);
        send8(8'd1,   8'd4,   1'b1, 1'b1, 16'd8);
        send8(8'd16,  8'd16,  1'b1, 1'b1, 16'd256);
        send8(8'd255, 8'd1,   1'b1, 1'b1, 16'd255);
        send8(8'd0,   8'd200, 1'b1, 1'b1, 16'd0);
        send8(8'd3,   8'd3,   1'b0, 1'b1, 16'd9);
        drain8();

        // mode=1 random: the APPROX_COLS=0 build must stay exact
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            send8(ra, rb, 1'b1, 1'b0, 16'd0);
        end
        drain8();

        // Backpressure: out_ready follows 1,0,0,1,...
        bp_en  = 1'b1;
        bp_idx = 0;
        set_ready();
        for (int i = 0; i < 10; i++) begin
            ra = 8'(i * 37 + 5);
            rb = 8'(255 - i * 13);
            arm_lat = (i == 0);
            send8(ra, rb, 1'b0, 1'b1, 16'(ra) * 16'(rb));
        end
        arm_lat = 1'b0;
        drain8();
        bp_en = 1'b0;
        set_ready();

        // Reset with three beats stalled in flight
        hold_en = 1'b1;
        set_ready();
        send8(8'd10, 8'd10, 1'b0, 1'b1, 16'd100);
        send8(8'd11, 8'd10, 1'b0, 1'b1, 16'd110);
        send8(8'd12, 8'd10, 1'b1, 1'b1, 16'd120);
        check("stalled_out_valid", {63'd0, out_valid}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_product", {48'd0, product}, 64'd0);
        check("midrst_out_mode", {63'd0, out_mode}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        q8.delete();
        q0.delete();
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        hold_en = 1'b0;
        set_ready();
        repeat (5) begin
            @(negedge clk);
            set_ready();
        end
        #2;
        check("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        set_ready();
        arm_lat = 1'b1;
        send8(8'd13, 8'd11, 1'b0, 1'b1, 16'd143);
        arm_lat = 1'b0;
        drain8();

        // WIDTH=16 build
        send16(16'hFFFF, 16'hFFFF, 1'b0, 32'd4294836225);
        send16(16'd0, 16'd65535, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) begin
            wa = 16'($urandom);
            wb = 16'($urandom);
            send16(wa, wb, 1'b0, 32'(wa) * 32'(wb));
        end
        send16(16'd1, 16'd1, 1'b1, 32'd1);
        drain16();

        // Exhaustive exact sweep, one beat per cycle
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                send8(8'(i), 8'(j), 1'b0, 1'b1, 16'(i * j));
            end
        end
        drain8();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
